// File: rtl/rotator_left_iterative_if.sv
// Handshake bundle for rotator_left_iterative: an input word plus rotation
// amount in, and the rotated word out, each with a valid/ready pair.
// The slave modport is the rotator; the master modport is its producer/consumer.
interface rotator_left_iterative_if #(
  parameter int WIDTH = 8
);
  localparam int AMOUNT_WIDTH = $clog2(WIDTH);

  logic [WIDTH-1:0]        input_data;
  logic [AMOUNT_WIDTH-1:0] input_rotation;
  logic                    input_valid;
  logic                    input_ready;
  logic [WIDTH-1:0]        output_data;
  logic                    output_valid;
  logic                    output_ready;

  modport master (
    output input_data,
    output input_rotation,
    output input_valid,
    input  input_ready,
    input  output_data,
    input  output_valid,
    output output_ready
  );

  modport slave (
    input  input_data,
    input  input_rotation,
    input  input_valid,
    output input_ready,
    output output_data,
    output output_valid,
    input  output_ready
  );
endinterface

// File: rtl/rotator_left_iterative.sv
// Iterative left rotator: rotates a word left by (amount mod WIDTH), resolving
// one binary stage of the amount per cycle so only one WIDTH-bit mux is needed.
// One word in flight; every output is driven from registers.
// Optional macro ROTATOR_LEFT_ITERATIVE_EARLY_EXIT_EN: leave the rotate phase
// as soon as no higher amount bits remain set (same result, shorter latency).
module rotator_left_iterative #(
  parameter int WIDTH = 8
) (
  input logic clock,
  input logic reset,
  rotator_left_iterative_if.slave bus
);
  localparam int AMOUNT_WIDTH = $clog2(WIDTH);
  localparam int STAGES       = AMOUNT_WIDTH;
  localparam logic [AMOUNT_WIDTH:0]   WIDTH_EXT  = (AMOUNT_WIDTH + 1)'(WIDTH);
  localparam logic [AMOUNT_WIDTH-1:0] WIDTH_AMT  = AMOUNT_WIDTH'(WIDTH);
  localparam logic [AMOUNT_WIDTH-1:0] LAST_STAGE = AMOUNT_WIDTH'(STAGES - 1);

  typedef enum logic [1:0] {
    IDLE,
    ROTATE,
    DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [WIDTH-1:0]        workData_q, workData_d;
  logic [AMOUNT_WIDTH-1:0] amount_q, amount_d;
  logic [AMOUNT_WIDTH-1:0] stage_q, stage_d;
  logic                    inReady_q;

  logic [AMOUNT_WIDTH-1:0] reducedAmount;
  logic [WIDTH-1:0]        stageOut;
  logic [2*WIDTH-1:0]      doubled;

  // Fold the incoming amount into 0..WIDTH-1; it is always below 2*WIDTH,
  // so one conditional subtraction is enough (wraps harmlessly when WIDTH is a power of two).
  always_comb begin
    reducedAmount = bus.input_rotation;
    if ({1'b0, bus.input_rotation} >= WIDTH_EXT) begin
      reducedAmount = bus.input_rotation - WIDTH_AMT;
    end
  end

  // Single shared rotator: rotate the working word left by 2^stage.
  always_comb begin
    stageOut = workData_q;
    doubled  = '0;
    for (int j = 0; j < STAGES; j++) begin
      if (stage_q == AMOUNT_WIDTH'(j)) begin
        doubled  = {workData_q, workData_q} << (2 ** j);
        stageOut = doubled[2*WIDTH-1:WIDTH];
      end
    end
  end

`ifdef ROTATOR_LEFT_ITERATIVE_EARLY_EXIT_EN
  logic upperZero;

  // True when no amount bit above the current stage is set, so later stages would only hold.
  always_comb begin
    upperZero = 1'b1;
    for (int j = 0; j < AMOUNT_WIDTH; j++) begin
      if ((j > int'(stage_q)) && amount_q[j]) begin
        upperZero = 1'b0;
      end
    end
  end
`endif

  // State register and datapath registers; reset discards any word in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      workData_q <= '0;
      amount_q   <= '0;
      stage_q    <= '0;
      inReady_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      workData_q <= workData_d;
      amount_q   <= amount_d;
      stage_q    <= stage_d;
      inReady_q  <= (state_d == IDLE);
    end
  end

  // Next-state logic: accept in IDLE, one stage per cycle in ROTATE, hold in DONE until taken.
  always_comb begin
    state_d    = state_q;
    workData_d = workData_q;
    amount_d   = amount_q;
    stage_d    = stage_q;
    case (state_q)
      IDLE: begin
        if (bus.input_valid && inReady_q) begin
          workData_d = bus.input_data;
          amount_d   = reducedAmount;
          stage_d    = '0;
          state_d    = ROTATE;
        end
      end
      ROTATE: begin
        if (amount_q[stage_q]) begin
          workData_d = stageOut;
        end
        stage_d = stage_q + 1'b1;
        if (stage_q == LAST_STAGE) begin
          state_d = DONE;
        end
`ifdef ROTATOR_LEFT_ITERATIVE_EARLY_EXIT_EN
        else if (upperZero) begin
          state_d = DONE;
        end
`endif
      end
      DONE: begin
        if (bus.output_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.input_ready  = inReady_q;
  assign bus.output_valid = (state_q == DONE);
  assign bus.output_data  = workData_q;

endmodule

// File: tb/tb_rotator_left_iterative.sv
// Directed bench for rotator_left_iterative: a WIDTH=8 and a WIDTH=5 instance,
// a vector table of {data, rotation, expected result, expected latency},
// plus hand-written backpressure and mid-rotation reset sequences.
// Honours ROTATOR_LEFT_ITERATIVE_EARLY_EXIT_EN for the expected latencies.
module tb_rotator_left_iterative;

  logic clock = 1'b0;
  logic reset = 1'b1;

  int checks = 0;
  int errors = 0;

  rotator_left_iterative_if #(.WIDTH(8)) bus8 ();
  rotator_left_iterative_if #(.WIDTH(5)) bus5 ();

  rotator_left_iterative #(.WIDTH(8)) dut8 (
    .clock (clock),
    .reset (reset),
    .bus   (bus8)
  );

  rotator_left_iterative #(.WIDTH(5)) dut5 (
    .clock (clock),
    .reset (reset),
    .bus   (bus5)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       w5;
    logic [7:0] data;
    logic [2:0] rot;
    logic [7:0] expData;
    int         latFull;
    int         latEarly;
  } vec_t;

  vec_t vecs[12];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic readyOf(input logic w5);
    return w5 ? bus5.input_ready : bus8.input_ready;
  endfunction

  function automatic logic validOf(input logic w5);
    return w5 ? bus5.output_valid : bus8.output_valid;
  endfunction

  function automatic logic [7:0] dataOf(input logic w5);
    return w5 ? {3'b000, bus5.output_data} : bus8.output_data;
  endfunction

  // Offer one word, then count rising edges after acceptance until output_valid shows.
  task automatic applyStimulus(input logic w5, input logic [7:0] data, input logic [2:0] rot,
                               output logic [7:0] res, output int lat);
    int guard;
    guard = 0;
    @(negedge clock);
    while (!readyOf(w5) && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 20) begin
      checks++;
      errors++;
      $display("[TB] FAIL ready_timeout: input_ready stuck at 0, expected 1");
    end
    if (w5) begin
      bus5.input_data     = data[4:0];
      bus5.input_rotation = rot;
      bus5.input_valid    = 1'b1;
    end else begin
      bus8.input_data     = data;
      bus8.input_rotation = rot;
      bus8.input_valid    = 1'b1;
    end
    @(posedge clock);
    #1;
    bus5.input_valid = 1'b0;
    bus8.input_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clock);
      #1;
      lat++;
    end while (!validOf(w5) && lat < 20);
    if (!validOf(w5)) begin
      checks++;
      errors++;
      $display("[TB] FAIL valid_timeout: output_valid stuck at 0, expected 1");
    end
    res = dataOf(w5);
  endtask

  logic [7:0] res;
  int         lat;
  int         expLat;
  logic       sawValid;

  initial begin
    vecs[0]  = '{1'b0, 8'h81, 3'd1, 8'h03, 3, 1};
    vecs[1]  = '{1'b0, 8'h01, 3'd7, 8'h80, 3, 3};
    vecs[2]  = '{1'b0, 8'hA5, 3'd0, 8'hA5, 3, 1};
    vecs[3]  = '{1'b0, 8'h81, 3'd2, 8'h06, 3, 2};
    vecs[4]  = '{1'b0, 8'h81, 3'd4, 8'h18, 3, 3};
    vecs[5]  = '{1'b0, 8'h12, 3'd3, 8'h90, 3, 2};
    vecs[6]  = '{1'b0, 8'h81, 3'd6, 8'h60, 3, 3};
    vecs[7]  = '{1'b0, 8'h0F, 3'd4, 8'hF0, 3, 3};
    vecs[8]  = '{1'b1, 8'h01, 3'd6, 8'h02, 3, 1};
    vecs[9]  = '{1'b1, 8'h01, 3'd5, 8'h01, 3, 1};
    vecs[10] = '{1'b1, 8'h13, 3'd2, 8'h0E, 3, 2};
    vecs[11] = '{1'b1, 8'h01, 3'd7, 8'h04, 3, 2};

    bus8.input_data = '0; bus8.input_rotation = '0; bus8.input_valid = 1'b0; bus8.output_ready = 1'b1;
    bus5.input_data = '0; bus5.input_rotation = '0; bus5.input_valid = 1'b0; bus5.output_ready = 1'b1;

    // Reset state
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset_valid", 32'(bus8.output_valid), 32'd0);
    checkOutput("reset_data", 32'(bus8.output_data), 32'd0);
    checkOutput("reset_ready", 32'(bus8.input_ready), 32'd0);
    checkOutput("reset_ready_w5", 32'(bus5.input_ready), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    checkOutput("ready_after_reset", 32'(bus8.input_ready), 32'd1);

    // Vector table
    for (int i = 0; i < 12; i++) begin
`ifdef ROTATOR_LEFT_ITERATIVE_EARLY_EXIT_EN
      expLat = vecs[i].latEarly;
`else
      expLat = vecs[i].latFull;
`endif
      applyStimulus(vecs[i].w5, vecs[i].data, vecs[i].rot, res, lat);
      checkOutput($sformatf("vec%0d_data", i), 32'(res), 32'(vecs[i].expData));
      checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'(expLat));
      checkOutput($sformatf("vec%0d_ready_in_done", i), 32'(readyOf(vecs[i].w5)), 32'd0);
      @(posedge clock);
      #1;
      checkOutput($sformatf("vec%0d_ready_after", i), 32'(readyOf(vecs[i].w5)), 32'd1);
      checkOutput($sformatf("vec%0d_valid_after", i), 32'(validOf(vecs[i].w5)), 32'd0);
    end

    // Backpressure: result held stable while the consumer stalls
    @(negedge clock);
    bus8.output_ready = 1'b0;
    applyStimulus(1'b0, 8'h81, 3'd1, res, lat);
    checkOutput("bp_data", 32'(res), 32'h03);
    for (int c = 0; c < 5; c++) begin
      @(posedge clock);
      #1;
      checkOutput($sformatf("bp_valid_c%0d", c), 32'(bus8.output_valid), 32'd1);
      checkOutput($sformatf("bp_hold_c%0d", c), 32'(bus8.output_data), 32'h03);
      checkOutput($sformatf("bp_ready_c%0d", c), 32'(bus8.input_ready), 32'd0);
    end
    @(negedge clock);
    bus8.output_ready = 1'b1;
    @(posedge clock);
    #1;
    checkOutput("bp_release_ready", 32'(bus8.input_ready), 32'd1);
    checkOutput("bp_release_valid", 32'(bus8.output_valid), 32'd0);

    // Reset mid-ROTATE discards the word in flight
    @(negedge clock);
    bus8.input_data = 8'h55;
    bus8.input_rotation = 3'd3;
    bus8.input_valid = 1'b1;
    @(posedge clock);
    #1;
    bus8.input_valid = 1'b0;
    checkOutput("rotate_ready_low", 32'(bus8.input_ready), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    checkOutput("midreset_valid", 32'(bus8.output_valid), 32'd0);
    checkOutput("midreset_data", 32'(bus8.output_data), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    sawValid = 1'b0;
    repeat (8) begin
      @(posedge clock);
      #1;
      if (bus8.output_valid) sawValid = 1'b1;
    end
    checkOutput("midreset_no_valid", 32'(sawValid), 32'd0);
    checkOutput("midreset_ready", 32'(bus8.input_ready), 32'd1);
    applyStimulus(1'b0, 8'h0F, 3'd4, res, lat);
    checkOutput("post_reset_data", 32'(res), 32'hF0);
    checkOutput("post_reset_latency", 32'(lat), 32'd3);
    @(posedge clock);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
